alu_op_sequencer: RTL and testbench

- Initiator side of the 13-bit registered ALU interface (opcode/x/y in; result/status out one clock later).
- Accepts operation commands from upstream over a valid/ready handshake and drives the ALU operand and opcode lines.
- Waits the ALU's fixed latency, then captures result and zero status and returns them downstream over a second valid/ready handshake.
- Guards divide/modulo by zero and keeps saturating operation and error counters.

---
 rtl/alu_op_sequencer_if.sv | 41 ++++
 rtl/alu_op_sequencer.sv | 119 +++++++++++
 tb/tb_alu_op_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU operand/result and response bundle between the sequencer and its environment.
// master is the sequencer's view; slave is the upstream/ALU/downstream side.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 13
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_opcode;
  logic [WIDTH-1:0] cmd_x;
  logic [WIDTH-1:0] cmd_y;

  logic [2:0]       alu_opcode;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] alu_result;
  logic             alu_status;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_x, cmd_y,
    output cmd_ready,
    output alu_opcode, alu_x, alu_y,
    input  alu_result, alu_status,
    output rsp_valid, rsp_result, rsp_zero, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_x, cmd_y,
    input  cmd_ready,
    input  alu_opcode, alu_x, alu_y,
    output alu_result, alu_status,
    input  rsp_valid, rsp_result, rsp_zero, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one ALU operation per command, waits the ALU latency, and returns the captured
// result over a response handshake; divide/modulo by zero is answered without issuing.
module alu_op_sequencer #(
  parameter int WIDTH   = 13,
  parameter int ALU_LAT = 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  alu_op_sequencer_if.master   io,
  output logic                 busy,
  input  logic                 cnt_clr,
  output logic [15:0]          op_count,
  output logic [7:0]           err_count
);

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       accept;
  logic       div_zero;
  logic       issue;
  logic       capture;
  logic       rsp_hs;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign accept   = (state == S_IDLE) && io.cmd_valid;
  assign div_zero = ((io.cmd_opcode == 3'b011) || (io.cmd_opcode == 3'b100)) &&
                    (io.cmd_y == '0);
  assign issue    = accept && !div_zero;
  assign capture  = (state == S_WAIT) && (wait_cnt == 4'd0);
  assign rsp_hs   = (state == S_RESP) && io.rsp_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    io.cmd_ready = 1'b0;
    io.rsp_valid = 1'b0;
    busy         = 1'b1;
    case (state)
      S_IDLE: begin
        io.cmd_ready = 1'b1;
        busy         = 1'b0;
        if (io.cmd_valid) state_nxt = div_zero ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = S_RESP;
      end
      S_RESP: begin
        io.rsp_valid = 1'b1;
        if (io.rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latency counter: loaded on issue, capture happens on the edge it reads zero
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                              wait_cnt <= 4'd0;
    else if (issue)                            wait_cnt <= LAT_INIT;
    else if (state == S_WAIT && wait_cnt != 0) wait_cnt <= wait_cnt - 4'd1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      io.alu_opcode <= 3'b000;
      io.alu_x      <= '0;
      io.alu_y      <= '0;
    end else if (issue) begin
      io.alu_opcode <= io.cmd_opcode;
      io.alu_x      <= io.cmd_x;
      io.alu_y      <= io.cmd_y;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      io.rsp_result <= '0;
      io.rsp_zero   <= 1'b0;
      io.rsp_err    <= 1'b0;
    end else if (accept && div_zero) begin
      io.rsp_result <= '0;
      io.rsp_zero   <= 1'b0;
      io.rsp_err    <= 1'b1;
    end else if (capture) begin
      io.rsp_result <= io.alu_result;
      io.rsp_zero   <= io.alu_status;
      io.rsp_err    <= 1'b0;
    end
  end

  // Clear wins over a same-edge increment
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      op_count  <= 16'd0;
      err_count <= 8'd0;
    end else if (cnt_clr) begin
      op_count  <= 16'd0;
      err_count <= 8'd0;
    end else if (rsp_hs) begin
      op_count <= sat_inc16(op_count);
      if (io.rsp_err) err_count <= sat_inc8(err_count);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a registered one-cycle ALU model on the operand lines.
module tb_alu_op_sequencer;
  localparam int W = 13;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        busy;
  logic        cnt_clr;
  logic [15:0] op_count;
  logic [7:0]  err_count;
  int          n_tests = 0;
  int          n_fail  = 0;

  alu_op_sequencer_if #(.WIDTH(W)) io ();

  alu_op_sequencer #(.WIDTH(W), .ALU_LAT(1)) dut (
    .aclk(aclk), .aresetn(aresetn), .io(io.master), .busy(busy),
    .cnt_clr(cnt_clr), .op_count(op_count), .err_count(err_count)
  );

  always #5 aclk = ~aclk;

  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] x, y);
    case (op)
      3'b000:  return x;
      3'b001:  return x + y;
      3'b010:  return x - y;
      3'b011:  return (y == '0) ? '0 : x / y;
      3'b100:  return (y == '0) ? '0 : x % y;
      3'b101:  return (x > y) ? x : y;
      3'b110:  return x >> 1;
      default: return x << 1;
    endcase
  endfunction

  always @(posedge aclk) begin
    io.alu_result <= alu_fn(io.alu_opcode, io.alu_x, io.alu_y);
    io.alu_status <= (alu_fn(io.alu_opcode, io.alu_x, io.alu_y) == '0);
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat);
    int guard;
    guard = 0;
    io.cmd_opcode = op; io.cmd_x = x; io.cmd_y = y; io.cmd_valid = 1'b1;
    while (!io.cmd_ready && guard < 50) begin step(); guard++; end
    step();
    io.cmd_valid = 1'b0;
    lat = 0;
    while (!io.rsp_valid && lat < 50) begin step(); lat++; end
    n_tests++; if (io.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rsp_timeout op=%0d got=%0b want=1", op, io.rsp_valid); end
  endtask

  task automatic handshake();
    io.rsp_ready = 1'b1;
    step();
    io.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) step();
    n_tests++; if (io.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%0b want=1", io.cmd_ready); end
    n_tests++; if (io.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%0b want=0", io.rsp_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b want=0", busy); end
    n_tests++; if ({io.rsp_err, io.rsp_zero, io.rsp_result} !== '0) begin n_fail++; $display("FAIL reset_rsp_data got=%0h want=0", {io.rsp_err, io.rsp_zero, io.rsp_result}); end
    n_tests++; if ({io.alu_opcode, io.alu_x, io.alu_y} !== '0) begin n_fail++; $display("FAIL reset_alu_lines got=%0h want=0", {io.alu_opcode, io.alu_x, io.alu_y}); end
    n_tests++; if ({op_count, err_count} !== 24'd0) begin n_fail++; $display("FAIL reset_counters got=%0h want=0", {op_count, err_count}); end
    @(negedge aclk);
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_add();
    io.cmd_opcode = 3'b001; io.cmd_x = 13'd5; io.cmd_y = 13'd7;
    io.cmd_valid = 1'b1; io.rsp_ready = 1'b1;
    step();
    io.cmd_valid = 1'b0;
    n_tests++; if ({io.alu_opcode, io.alu_x, io.alu_y} !== {3'b001, 13'd5, 13'd7}) begin n_fail++; $display("FAIL add_alu_lines got=%0h want=%0h", {io.alu_opcode, io.alu_x, io.alu_y}, {3'b001, 13'd5, 13'd7}); end
    n_tests++; if ({busy, io.cmd_ready, io.rsp_valid} !== 3'b100) begin n_fail++; $display("FAIL add_wait_flags got=%0b want=100", {busy, io.cmd_ready, io.rsp_valid}); end
    step();
    n_tests++; if (io.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_rsp_early got=%0b want=0", io.rsp_valid); end
    step();
    n_tests++; if (io.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_rsp_latency got=%0b want=1", io.rsp_valid); end
    n_tests++; if ({io.rsp_err, io.rsp_zero, io.rsp_result} !== {1'b0, 1'b0, 13'd12}) begin n_fail++; $display("FAIL add_result got=%0h want=%0h", {io.rsp_err, io.rsp_zero, io.rsp_result}, {1'b0, 1'b0, 13'd12}); end
    step();
    io.rsp_ready = 1'b0;
    n_tests++; if (io.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_rsp_drop got=%0b want=0", io.rsp_valid); end
    n_tests++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL add_op_count got=%0d want=1", op_count); end
  endtask

  task automatic test_zero_flag();
    int lat;
    send_cmd(3'b010, 13'd7, 13'd7, lat);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL sub_latency got=%0d want=2", lat); end
    n_tests++; if ({io.rsp_zero, io.rsp_result} !== {1'b1, 13'd0}) begin n_fail++; $display("FAIL sub_zero got=%0h want=%0h", {io.rsp_zero, io.rsp_result}, {1'b1, 13'd0}); end
    handshake();
    send_cmd(3'b111, 13'h1000, 13'd0, lat);
    n_tests++; if ({io.rsp_err, io.rsp_zero, io.rsp_result} !== {1'b0, 1'b1, 13'd0}) begin n_fail++; $display("FAIL shl_wrap got=%0h want=%0h", {io.rsp_err, io.rsp_zero, io.rsp_result}, {1'b0, 1'b1, 13'd0}); end
    handshake();
  endtask

  task automatic test_div_zero();
    int lat;
    send_cmd(3'b011, 13'd100, 13'd0, lat);
    n_tests++; if (lat !== 0) begin n_fail++; $display("FAIL div0_immediate got=%0d want=0", lat); end
    n_tests++; if ({io.rsp_err, io.rsp_zero, io.rsp_result} !== {1'b1, 1'b0, 13'd0}) begin n_fail++; $display("FAIL div0_rsp got=%0h want=%0h", {io.rsp_err, io.rsp_zero, io.rsp_result}, {1'b1, 1'b0, 13'd0}); end
    n_tests++; if ({io.alu_opcode, io.alu_x, io.alu_y} !== {3'b111, 13'h1000, 13'd0}) begin n_fail++; $display("FAIL div0_alu_hold got=%0h want=%0h", {io.alu_opcode, io.alu_x, io.alu_y}, {3'b111, 13'h1000, 13'd0}); end
    handshake();
    n_tests++; if ({op_count, err_count} !== {16'd4, 8'd1}) begin n_fail++; $display("FAIL div0_counts got=%0h want=%0h", {op_count, err_count}, {16'd4, 8'd1}); end
    send_cmd(3'b100, 13'd100, 13'd7, lat);
    n_tests++; if ({io.rsp_err, io.rsp_result} !== {1'b0, 13'd2}) begin n_fail++; $display("FAIL mod_result got=%0h want=%0h", {io.rsp_err, io.rsp_result}, {1'b0, 13'd2}); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    int g;
    send_cmd(3'b101, 13'd9, 13'd20, lat);
    io.cmd_opcode = 3'b001; io.cmd_x = 13'd2; io.cmd_y = 13'd3; io.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if ({io.rsp_valid, io.cmd_ready, io.rsp_result} !== {1'b1, 1'b0, 13'd20}) begin n_fail++; $display("FAIL bp_hold cyc=%0d got=%0h want=%0h", i, {io.rsp_valid, io.cmd_ready, io.rsp_result}, {1'b1, 1'b0, 13'd20}); end
    end
    io.rsp_ready = 1'b1;
    step();
    io.rsp_ready = 1'b0;
    n_tests++; if ({io.rsp_valid, busy, io.cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL bp_no_same_edge_accept got=%0b want=001", {io.rsp_valid, busy, io.cmd_ready}); end
    step();
    io.cmd_valid = 1'b0;
    n_tests++; if ({busy, io.alu_x} !== {1'b1, 13'd2}) begin n_fail++; $display("FAIL bp_second_accept got=%0h want=%0h", {busy, io.alu_x}, {1'b1, 13'd2}); end
    g = 0;
    while (!io.rsp_valid && g < 20) begin step(); g++; end
    n_tests++; if (io.rsp_result !== 13'd5) begin n_fail++; $display("FAIL bp_second_result got=%0d want=5", io.rsp_result); end
    handshake();
    n_tests++; if (op_count !== 16'd7) begin n_fail++; $display("FAIL bp_op_count got=%0d want=7", op_count); end
  endtask

  task automatic test_reset_midop();
    int lat;
    io.cmd_opcode = 3'b001; io.cmd_x = 13'd3; io.cmd_y = 13'd4; io.cmd_valid = 1'b1;
    step();
    io.cmd_valid = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midop_in_wait got=%0b want=1", busy); end
    #2 aresetn = 1'b0;
    #1;
    n_tests++; if ({io.rsp_valid, busy, io.cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL midop_async_flags got=%0b want=001", {io.rsp_valid, busy, io.cmd_ready}); end
    n_tests++; if ({op_count, err_count} !== 24'd0) begin n_fail++; $display("FAIL midop_counters got=%0h want=0", {op_count, err_count}); end
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) step();
    n_tests++; if ({io.rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL midop_stale_ignored got=%0b want=00", {io.rsp_valid, busy}); end
    send_cmd(3'b000, 13'd3, 13'd0, lat);
    n_tests++; if (io.rsp_result !== 13'd3) begin n_fail++; $display("FAIL midop_pass got=%0d want=3", io.rsp_result); end
    handshake();
  endtask

  task automatic test_err_saturation();
    int lat;
    for (int i = 0; i < 256; i++) begin
      send_cmd(3'b011, 13'd1, 13'd0, lat);
      handshake();
      if (i == 254) begin
        n_tests++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL err_reach_max got=%0h want=ff", err_count); end
      end
    end
    n_tests++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL err_saturate got=%0h want=ff", err_count); end
    n_tests++; if (op_count !== 16'd257) begin n_fail++; $display("FAIL sat_op_count got=%0d want=257", op_count); end
  endtask

  task automatic test_cnt_clr();
    int lat;
    send_cmd(3'b011, 13'd1, 13'd0, lat);
    io.rsp_ready = 1'b1; cnt_clr = 1'b1;
    step();
    io.rsp_ready = 1'b0; cnt_clr = 1'b0;
    n_tests++; if ({op_count, err_count, io.rsp_valid} !== 25'd0) begin n_fail++; $display("FAIL clr_with_hs got=%0h want=0", {op_count, err_count, io.rsp_valid}); end
    send_cmd(3'b001, 13'd1, 13'd1, lat);
    n_tests++; if (io.rsp_result !== 13'd2) begin n_fail++; $display("FAIL clr_next_result got=%0d want=2", io.rsp_result); end
    handshake();
    n_tests++; if ({op_count, err_count} !== {16'd1, 8'd0}) begin n_fail++; $display("FAIL clr_recount got=%0h want=%0h", {op_count, err_count}, {16'd1, 8'd0}); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    io.cmd_valid = 1'b0; io.cmd_opcode = 3'b000; io.cmd_x = '0; io.cmd_y = '0;
    io.rsp_ready = 1'b0; cnt_clr = 1'b0; aresetn = 1'b0;
    test_reset();
    test_add();
    test_zero_flag();
    test_div_zero();
    test_back_to_back();
    test_reset_midop();
    test_err_saturation();
    test_cnt_clr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
